// File: rtl/mips_defs_pkg.sv
// Shared MIPS front-end definitions: default vectors, fetch state and redirect-source encodings.
package mips_defs;

   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0080;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_e;

   typedef enum logic [1:0] {
      RD_NONE = 2'd0,
      RD_EXC  = 2'd1,
      RD_BR   = 2'd2,
      RD_JMP  = 2'd3
   } redir_src_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_ctrl_npc.sv
// Sequential next-PC incrementer; wraps silently at the top of the address space.
module Npc (
   input  logic [31:0] npc_inpc,
   output logic [31:0] npc_outpc
);

   assign npc_outpc = npc_inpc + 32'd4;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch sequencer: imem handshake, decode buffer, redirect tracking.
module pc_fetch_ctrl
   import mips_defs::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        exc_en,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp_en,
   input  logic [31:0] jmp_target,
   output logic [31:0] pc_out,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [31:0] inst_in,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   output logic        inst_valid
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         req_q, req_d;
   logic [31:0]  inst_q, inst_d;
   logic [31:0]  ipc_q, ipc_d;
   logic         valid_q, valid_d;
   logic         pend_q, pend_d;
   logic [31:0]  pend_tgt_q, pend_tgt_d;

   redir_src_e   redir_src;
   logic         redir;
   logic [31:0]  redir_tgt;
   logic [31:0]  seq_pc;

   Npc u_npc (
      .npc_inpc  (pc_q),
      .npc_outpc (seq_pc)
   );

   always_comb begin
      if (exc_en)        redir_src = RD_EXC;
      else if (br_taken) redir_src = RD_BR;
      else if (jmp_en)   redir_src = RD_JMP;
      else               redir_src = RD_NONE;

      case (redir_src)
         RD_EXC:  redir_tgt = word_align(EXC_VECTOR);
         RD_BR:   redir_tgt = word_align(br_target);
         RD_JMP:  redir_tgt = word_align(jmp_target);
         default: redir_tgt = pc_q;
      endcase
      redir = (redir_src != RD_NONE);
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      ipc_d      = ipc_q;
      valid_d    = valid_q;
      pend_d     = pend_q;
      pend_tgt_d = pend_tgt_q;

      case (state_q)
         ST_BOOT: begin
            if (redir) pc_d = redir_tgt;
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_ack) begin
               // A redirect seen at any point during the fetch poisons the returned word.
               if (redir || pend_q) begin
                  pc_d   = redir ? redir_tgt : pend_tgt_q;
                  pend_d = 1'b0;
               end else begin
                  inst_d  = inst_in;
                  ipc_d   = pc_q;
                  valid_d = 1'b1;
                  pc_d    = seq_pc;
                  state_d = ST_HOLD;
               end
            end else if (redir) begin
               pend_d     = 1'b1;
               pend_tgt_d = redir_tgt;
            end
         end
         ST_HOLD: begin
            if (redir) begin
               valid_d = 1'b0;
               pc_d    = redir_tgt;
               state_d = ST_FETCH;
            end else if (!stall) begin
               valid_d = 1'b0;
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_BOOT;
      endcase

      req_d = (state_d == ST_FETCH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_PC;
         req_q      <= 1'b0;
         inst_q     <= '0;
         ipc_q      <= '0;
         valid_q    <= 1'b0;
         pend_q     <= 1'b0;
         pend_tgt_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_q      <= req_d;
         inst_q     <= inst_d;
         ipc_q      <= ipc_d;
         valid_q    <= valid_d;
         pend_q     <= pend_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end

   assign pc_out     = pc_q;
   assign imem_req   = req_q;
   assign inst_out   = inst_q;
   assign inst_pc    = ipc_q;
   assign inst_valid = valid_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: transaction-level fetch model plus directed scenarios.
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0, exc_en = 1'b0, br_taken = 1'b0, jmp_en = 1'b0, imem_ack = 1'b0;
   logic [31:0] br_target = '0, jmp_target = '0, inst_in = '0;
   logic [31:0] pc_out, inst_out, inst_pc;
   logic        imem_req, inst_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .EXC_VECTOR(32'h0000_0080)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .exc_en     (exc_en),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .jmp_en     (jmp_en),
      .jmp_target (jmp_target),
      .pc_out     (pc_out),
      .imem_req   (imem_req),
      .imem_ack   (imem_ack),
      .inst_in    (inst_in),
      .inst_out   (inst_out),
      .inst_pc    (inst_pc),
      .inst_valid (inst_valid)
   );

   // Model: "in boot", "fetch in flight", "word held", optional pending redirect target.
   bit          m_boot = 1'b1, m_busy = 1'b0, m_have = 1'b0, m_pend = 1'b0;
   logic [31:0] m_pc = '0, m_word = '0, m_wpc = '0, m_ptgt = '0;

   task automatic model_reset();
      m_boot = 1'b1; m_busy = 1'b0; m_have = 1'b0; m_pend = 1'b0;
      m_pc = 32'h0; m_word = '0; m_wpc = '0; m_ptgt = '0;
   endtask

   task automatic model_step();
      bit          rd;
      logic [31:0] tgt;
      rd  = exc_en || br_taken || jmp_en;
      tgt = exc_en ? 32'h80 : (br_taken ? (br_target & 32'hFFFF_FFFC) : (jmp_target & 32'hFFFF_FFFC));
      if (m_boot) begin
         if (rd) m_pc = tgt;
         m_boot = 1'b0;
         m_busy = 1'b1;
      end else if (m_busy) begin
         if (imem_ack) begin
            if (rd) begin
               m_pc = tgt; m_pend = 1'b0;
            end else if (m_pend) begin
               m_pc = m_ptgt; m_pend = 1'b0;
            end else begin
               m_word = inst_in; m_wpc = m_pc; m_have = 1'b1;
               m_pc = m_pc + 32'd4; m_busy = 1'b0;
            end
         end else if (rd) begin
            m_pend = 1'b1; m_ptgt = tgt;
         end
      end else begin
         if (rd) begin
            m_have = 1'b0; m_pc = tgt; m_busy = 1'b1;
         end else if (!stall) begin
            m_have = 1'b0; m_busy = 1'b1;
         end
      end
   endtask

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      cmp("m_pc_out", pc_out, m_pc);
      cmp("m_imem_req", {31'b0, imem_req}, {31'b0, m_busy});
      cmp("m_inst_valid", {31'b0, inst_valid}, {31'b0, m_have});
      cmp("m_inst_out", inst_out, m_word);
      cmp("m_inst_pc", inst_pc, m_wpc);
   end

   task automatic cyc();
      @(posedge clk);
      if (!rst) model_step();
      #1;
   endtask

   task automatic tick(input bit ack, input logic [31:0] data, input bit stl,
                       input bit exc, input bit br, input logic [31:0] bt,
                       input bit jmp, input logic [31:0] jt);
      imem_ack = ack; inst_in = data; stall = stl;
      exc_en = exc; br_taken = br; br_target = bt; jmp_en = jmp; jmp_target = jt;
      cyc();
      imem_ack = 1'b0; exc_en = 1'b0; br_taken = 1'b0; jmp_en = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      cmp("rst_pc", pc_out, 32'h0);
      cmp("rst_req", {31'b0, imem_req}, 32'h0);
      cmp("rst_valid", {31'b0, inst_valid}, 32'h0);
      rst = 1'b0;

      // 1: ack every cycle
      tick(1, 32'hDEAD_0000, 0, 0, 0, 0, 0, 0);
      cmp("t1_boot_req", {31'b0, imem_req}, 32'h1);
      cmp("t1_boot_pc", pc_out, 32'h0);
      for (int unsigned i = 0; i < 4; i++) begin
         tick(1, 32'hA000_0000 + i, 0, 0, 0, 0, 0, 0);
         cmp("t1_valid", {31'b0, inst_valid}, 32'h1);
         cmp("t1_inst_pc", inst_pc, 32'h4 * i);
         cmp("t1_inst_out", inst_out, 32'hA000_0000 + i);
         cmp("t1_hold_req", {31'b0, imem_req}, 32'h0);
         if (i < 3) begin
            tick(1, 32'hBAD0_0000, 0, 0, 0, 0, 0, 0);
            cmp("t1_fetch_pc", pc_out, 32'h4 * (i + 1));
            cmp("t1_gap_valid", {31'b0, inst_valid}, 32'h0);
         end
      end

      // 2: stall in HOLD
      for (int unsigned i = 0; i < 3; i++) begin
         tick(0, 0, 1, 0, 0, 0, 0, 0);
         cmp("t2_inst_pc", inst_pc, 32'hC);
         cmp("t2_pc", pc_out, 32'h10);
         cmp("t2_req", {31'b0, imem_req}, 32'h0);
      end
      tick(0, 0, 0, 0, 0, 0, 0, 0);
      cmp("t2_resume_req", {31'b0, imem_req}, 32'h1);
      cmp("t2_resume_pc", pc_out, 32'h10);

      // 3: branch during fetch, then jmp/exc while pending
      tick(0, 0, 0, 0, 1, 32'h40, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0, 0);
      tick(1, 32'h1111_1111, 0, 0, 0, 0, 0, 0);
      cmp("t3_drop_valid", {31'b0, inst_valid}, 32'h0);
      cmp("t3_pc", pc_out, 32'h40);
      tick(0, 0, 0, 0, 0, 0, 1, 32'h100);
      tick(0, 0, 0, 1, 0, 0, 0, 0);
      tick(1, 32'h2222_2222, 0, 0, 0, 0, 0, 0);
      cmp("t3_exc_pc", pc_out, 32'h80);
      cmp("t3_exc_valid", {31'b0, inst_valid}, 32'h0);
      tick(1, 32'h3333_3333, 0, 0, 0, 0, 0, 0);
      cmp("t3_inst_pc", inst_pc, 32'h80);
      tick(0, 0, 0, 0, 0, 0, 0, 0);

      // 4: all redirects with ack in one cycle
      tick(1, 32'h4444_4444, 0, 1, 1, 32'h200, 1, 32'h300);
      cmp("t4_pc", pc_out, 32'h80);
      cmp("t4_valid", {31'b0, inst_valid}, 32'h0);
      tick(1, 32'h5555_5555, 0, 0, 0, 0, 0, 0);
      tick(0, 0, 1, 0, 1, 32'h43, 0, 0);
      cmp("t4_flush_valid", {31'b0, inst_valid}, 32'h0);
      cmp("t4_align_pc", pc_out, 32'h40);

      // 5: wrap at top of address space
      tick(1, 32'h6666_6666, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      tick(1, 32'h7777_7777, 0, 0, 0, 0, 0, 0);
      cmp("t5_inst_pc", inst_pc, 32'hFFFF_FFFC);
      cmp("t5_pc", pc_out, 32'h0);
      tick(0, 0, 0, 0, 0, 0, 0, 0);
      tick(1, 32'h8888_8888, 0, 0, 0, 0, 1, 32'h200);
      cmp("t6_pre_pc", pc_out, 32'h200);

      // 6: async reset mid-fetch, late ack ignored
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      cmp("t6_req", {31'b0, imem_req}, 32'h0);
      cmp("t6_pc", pc_out, 32'h0);
      cmp("t6_inst_out", inst_out, 32'h0);
      cmp("t6_valid", {31'b0, inst_valid}, 32'h0);
      tick(1, 32'h9999_9999, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      tick(1, 32'h9999_9999, 0, 0, 0, 0, 0, 0);
      cmp("t6_boot_pc", pc_out, 32'h0);
      cmp("t6_boot_valid", {31'b0, inst_valid}, 32'h0);
      tick(1, 32'hCAFE_0001, 0, 0, 0, 0, 0, 0);
      cmp("t6_first_inst", inst_out, 32'hCAFE_0001);
      cmp("t6_first_pc", inst_pc, 32'h0);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
